bmp_stream_writer: RTL and testbench
====================================

Name: bmp_stream_writer

Overview:
- Synthesizable BMP encoder: the write end of the brightness-adjust image path.
- Accepts an 8-bit grayscale pixel stream, typically from the brightness-adjust datapath.
- Emits a complete 8-bpp BMP file as a byte stream: 54-byte header, 1024-byte gray palette, then pixel rows padded to 4-byte stride.
- The byte stream feeds a file dump in simulation or a DMA/UART sink on Zynq PL.

Parameters:
- IMG_W, 400, image width in pixels (1..4095).
- IMG_H, 400, image height in rows (1..4095); positive, so rows are stored bottom-up.
- PPM, 2835, horizontal/vertical resolution field value (pixels per metre).

Ports:
- clk  in  1  system clock (100 MHz nominal).
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; begins one file; ignored unless in IDLE.
- s_pix  in  8  grayscale pixel.
- s_valid  in  1  pixel valid.
- s_ready  out  1  pixel accepted when s_valid && s_ready.
- m_data  out  8  output file byte.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts a byte when m_valid && m_ready.
- m_last  out  1  high with the final byte of the file.
- busy  out  1  high from the cycle after start until the last byte is accepted.
- done  out  1  one-cycle pulse in the cycle after the last byte is accepted.

Behaviour:
- Derived constants:
  - STRIDE = ((IMG_W+3)/4)*4.
  - PAD = STRIDE-IMG_W (0..3).
  - OFFSET = 1078.
  - IMG_BYTES = STRIDE*IMG_H.
  - FSIZE = OFFSET+IMG_BYTES.
  - All multi-byte fields are little-endian.
- Header bytes 0..53:
  - "BM".
  - FSIZE (4 bytes); reserved 0 (4 bytes); OFFSET (4 bytes).
  - 40 (4 bytes); IMG_W (4 bytes); IMG_H (4 bytes).
  - planes 1 (2 bytes); bpp 8 (2 bytes); compression 0 (4 bytes).
  - IMG_BYTES (4 bytes); PPM (4 bytes); PPM (4 bytes).
  - colours used 256 (4 bytes); important 0 (4 bytes).
- Palette bytes 54..1077: entry k occupies 4 bytes {k,k,k,0} (B,G,R,reserved).
- FSM states: IDLE, HDR, PAL, PIX, PAD, DONE.
  - IDLE -> HDR on start.
  - HDR: byte index 0..53; advances to PAL after byte 53 is loaded into the output register.
  - PAL: index 0..1023.
  - PIX: column counter 0..IMG_W-1, row counter 0..IMG_H-1. At the end of a row, go to PAD if PAD>0; otherwise go to PIX for the next row, or DONE after the last row.
  - PAD: emits PAD bytes of 0x00, then returns to PIX or goes to DONE.
  - DONE: waits for the last byte to be accepted, pulses done, returns to IDLE.
- Output register stage:
  - It loads when (!m_valid || m_ready) and the FSM has a byte to supply.
  - m_data, m_valid and m_last are held stable while m_valid && !m_ready.
- Pixel path:
  - s_ready = (state==PIX) && (!m_valid || m_ready); it is combinational from state and the output register.
  - A pixel accepted in cycle N appears on m_data in cycle N+1 (1-cycle latency).
  - Pixels pass through unmodified, in arrival order. Upstream supplies the bottom row first.
- s_ready is 0 in every state except PIX. Pixels presented outside PIX are not consumed.
- m_last is asserted only on byte FSIZE-1, which is the last pad byte or the last pixel.
- Counters: byte index 11 bits, column 12 bits, row 12 bits. No wrap; each counter clears on its state exit.
- A start pulse while not in IDLE is ignored and has no side effects.
- Reset values: state IDLE, all counters 0, m_data 0x00, m_valid 0, m_last 0, s_ready 0, busy 0, done 0.
- Reset mid-frame aborts immediately: the next cycle shows IDLE with m_valid 0, and a partial file is not completed.
- start asserted in the same cycle as rst: rst wins.

Decomposition:
- Package bmp_pkg holds:
  - BMP_HDR_BYTES=54, BMP_PAL_BYTES=1024, BMP_OFFSET=1078.
  - The state enum.
  - A function hdr_byte(idx, w, h) returning header byte idx, implemented as a case ROM.
  - A function stride(w).
- One sub-module is natural: bmp_hdr_rom, a combinational header plus palette byte generator indexed 0..1077. The FSM and output register stay in the top.

Test Plan:
- 400x400 header: start with m_ready=1.
  - Bytes 0..1 = 0x42,0x4D.
  - Bytes 2..5 = 0x36,0x75,0x02,0x00 (161078).
  - Bytes 10..13 = 0x36,0x04,0x00,0x00.
  - Bytes 18..19 = 0x90,0x01.
  - Bytes 34..37 = 0x00,0x71,0x02,0x00 (160000).
- Palette: bytes 54..57 = 0,0,0,0; bytes 1074..1077 = 0xFF,0xFF,0xFF,0x00.
- Padding, IMG_W=3, IMG_H=2: pixels 0x10..0x15 produce file bytes 1078..1085 = 10,11,12,00,13,14,15,00. Total 1086 bytes; m_last on byte 1085; done pulses once.
- Backpressure: toggle m_ready pseudo-randomly, with s_valid gaps.
  - Output byte sequence is identical to the m_ready=1 run.
  - m_data is stable while stalled.
  - s_ready=0 whenever m_valid && !m_ready.
- Protocol misuse:
  - A second start during PIX is ignored and the byte count is unchanged.
  - s_valid held high during HDR consumes no pixel.
- Reset mid-palette: assert rst at byte 600, then start again. A full correct file is produced from byte 0, with 0x42 first.

Source files
------------

// File: rtl/bmp_pkg.sv
// Shared constants, FSM state type and header helpers for the 8-bpp BMP writer.
// Header and palette geometry are fixed by the BMP format and the 256-entry gray palette.
package bmp_pkg;

    localparam int BMP_HDR_BYTES = 54;
    localparam int BMP_PAL_BYTES = 1024;
    localparam int BMP_OFFSET    = 1078;

    typedef enum logic [2:0] {IDLE, HDR, PAL, PIX, PAD, DONE} bmp_state_t;

    function automatic logic [31:0] stride(input logic [31:0] w);
        return (w + 32'd3) & ~32'd3;
    endfunction

    // Every multi-byte header field starts at an offset of 2 mod 4, so (idx-2)/4 selects
    // the field and (idx-2)%4 the little-endian byte; planes and bpp share one word.
    function automatic logic [7:0] hdr_byte(input logic [5:0]  idx,
                                            input logic [31:0] w,
                                            input logic [31:0] h,
                                            input logic [31:0] ppm);
        logic [31:0] img_bytes;
        logic [31:0] field;
        logic [31:0] shifted;
        logic [5:0]  rel;
        img_bytes = stride(w) * h;
        rel       = idx - 6'd2;
        case (rel[5:2])
            4'd0:    field = 32'(BMP_OFFSET) + img_bytes;
            4'd2:    field = 32'(BMP_OFFSET);
            4'd3:    field = 32'd40;
            4'd4:    field = w;
            4'd5:    field = h;
            4'd6:    field = 32'h0008_0001;
            4'd8:    field = img_bytes;
            4'd9:    field = ppm;
            4'd10:   field = ppm;
            4'd11:   field = 32'd256;
            default: field = 32'd0;
        endcase
        shifted = field >> {rel[1:0], 3'b000};
        if (idx == 6'd0) return 8'h42;
        if (idx == 6'd1) return 8'h4D;
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/bmp_stream_writer_if.sv
// Pixel input stream and file byte output stream of the BMP writer.
// master is the writer side, slave is the producer/consumer side around it.
interface bmp_stream_writer_if;

    logic [7:0] s_pix;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (
        input  s_pix, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport slave (
        output s_pix, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

endinterface

// File: rtl/bmp_hdr_rom.sv
// Combinational byte source for the file prefix: 54 header bytes followed by
// the 1024-byte gray palette, addressed 0..1077.
module bmp_hdr_rom
    import bmp_pkg::*;
#(
    parameter int IMG_W = 400,
    parameter int IMG_H = 400,
    parameter int PPM   = 2835
) (
    input  logic [10:0] idx_i,
    output logic [7:0]  byte_o
);

    logic [9:0] pal_idx;

    always_comb begin
        pal_idx = 10'(idx_i - 11'(BMP_HDR_BYTES));
        if (idx_i < 11'(BMP_HDR_BYTES)) begin
            byte_o = hdr_byte(idx_i[5:0], 32'(IMG_W), 32'(IMG_H), 32'(PPM));
        end else if (pal_idx[1:0] == 2'd3) begin
            byte_o = 8'h00;
        end else begin
            byte_o = pal_idx[9:2];
        end
    end

endmodule

// File: rtl/bmp_stream_writer.sv
// Streams a complete 8-bpp grayscale BMP file: header, gray palette, then the
// incoming pixel rows padded to a 4-byte stride, through one output register.
module bmp_stream_writer
    import bmp_pkg::*;
#(
    parameter int IMG_W = 400,
    parameter int IMG_H = 400,
    parameter int PPM   = 2835
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    bmp_stream_writer_if.master bus,
    output logic                busy,
    output logic                done
);

    localparam logic [31:0] STRIDE   = stride(32'(IMG_W));
    localparam int          PAD_N    = int'(STRIDE) - IMG_W;
    localparam logic [11:0] COL_LAST = 12'(IMG_W - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMG_H - 1);
    localparam logic [10:0] PAD_LAST = 11'(PAD_N - 1);
    localparam logic [10:0] HDR_LAST = 11'(BMP_HDR_BYTES - 1);
    localparam logic [10:0] PAL_LAST = 11'(BMP_PAL_BYTES - 1);

    bmp_state_t  state_q;
    logic [10:0] idx_q;
    logic [11:0] col_q;
    logic [11:0] row_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        last_q;
    logic        busy_q;
    logic        done_q;

    logic        out_free;
    logic        s_ready_w;
    logic [10:0] rom_idx;
    logic [7:0]  rom_byte;

    // The output register can take a new byte when empty or being drained this cycle.
    assign out_free  = !valid_q || bus.m_ready;
    assign s_ready_w = (state_q == PIX) && out_free;
    assign rom_idx   = (state_q == PAL) ? idx_q + 11'(BMP_HDR_BYTES) : idx_q;

    bmp_hdr_rom #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PPM   (PPM)
    ) u_rom (
        .idx_i  (rom_idx),
        .byte_o (rom_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 11'd0;
            col_q   <= 12'd0;
            row_q   <= 12'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (valid_q && bus.m_ready) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= HDR;
                        busy_q  <= 1'b1;
                    end
                end
                HDR: begin
                    if (out_free) begin
                        data_q  <= rom_byte;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        if (idx_q == HDR_LAST) begin
                            idx_q   <= 11'd0;
                            state_q <= PAL;
                        end else begin
                            idx_q <= idx_q + 11'd1;
                        end
                    end
                end
                PAL: begin
                    if (out_free) begin
                        data_q  <= rom_byte;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        if (idx_q == PAL_LAST) begin
                            idx_q   <= 11'd0;
                            state_q <= PIX;
                        end else begin
                            idx_q <= idx_q + 11'd1;
                        end
                    end
                end
                PIX: begin
                    if (bus.s_valid && s_ready_w) begin
                        data_q  <= bus.s_pix;
                        valid_q <= 1'b1;
                        last_q  <= (PAD_N == 0) && (col_q == COL_LAST) && (row_q == ROW_LAST);
                        if (col_q == COL_LAST) begin
                            col_q <= 12'd0;
                            if (PAD_N != 0) begin
                                state_q <= PAD;
                            end else if (row_q == ROW_LAST) begin
                                row_q   <= 12'd0;
                                state_q <= DONE;
                            end else begin
                                row_q <= row_q + 12'd1;
                            end
                        end else begin
                            col_q <= col_q + 12'd1;
                        end
                    end
                end
                PAD: begin
                    if (out_free) begin
                        data_q  <= 8'h00;
                        valid_q <= 1'b1;
                        last_q  <= (idx_q == PAD_LAST) && (row_q == ROW_LAST);
                        if (idx_q == PAD_LAST) begin
                            idx_q <= 11'd0;
                            if (row_q == ROW_LAST) begin
                                row_q   <= 12'd0;
                                state_q <= DONE;
                            end else begin
                                row_q   <= row_q + 12'd1;
                                state_q <= PIX;
                            end
                        end else begin
                            idx_q <= idx_q + 11'd1;
                        end
                    end
                end
                DONE: begin
                    if (valid_q && bus.m_ready) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = s_ready_w;
    assign bus.m_data  = data_q;
    assign bus.m_valid = valid_q;
    assign bus.m_last  = last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Bench for bmp_stream_writer: a 400x400 instance for header/palette bytes and a
// 3x2 instance for complete padded files under backpressure, misuse and reset.
module tb_bmp_stream_writer;

    localparam int TW      = 3;
    localparam int TH      = 2;
    localparam int TPPM    = 2835;
    localparam int TSTRIDE = ((TW + 3) / 4) * 4;
    localparam int TPAD    = TSTRIDE - TW;
    localparam int TFSIZE  = 1078 + TSTRIDE * TH;
    localparam int NPIX    = TW * TH;

    logic clk = 1'b0;
    logic rst;
    logic start, start_b;
    logic busy, done, busy_b, done_b;

    always #5 clk = ~clk;

    bmp_stream_writer_if ifc ();
    bmp_stream_writer_if ifc_b ();

    bmp_stream_writer #(.IMG_W(TW), .IMG_H(TH), .PPM(TPPM)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(ifc.master), .busy(busy), .done(done)
    );

    bmp_stream_writer #(.IMG_W(400), .IMG_H(400), .PPM(2835)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(ifc_b.master), .busy(busy_b), .done(done_b)
    );

    int         tests = 0;
    int         fails = 0;
    logic [8:0] sb[$];
    logic [7:0] cap[0:2047];
    int         rx_cnt = 0;
    int         done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       mon_en = 1'b0;
    logic [7:0] big_cap[0:1077];
    int         big_cnt = 0;
    int         pix_n;
    bit         bp, gaps;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push8(input logic [7:0] b);
        sb.push_back({1'b0, b});
    endtask

    task automatic put16(input int v);
        logic [31:0] x;
        x = 32'(v);
        push8(x[7:0]); push8(x[15:8]);
    endtask

    task automatic put32(input int v);
        logic [31:0] x;
        x = 32'(v);
        push8(x[7:0]); push8(x[15:8]); push8(x[23:16]); push8(x[31:24]);
    endtask

    // Expected file prefix for the 3x2 image: BMP header fields then gray palette.
    task automatic push_prefix();
        push8(8'h42); push8(8'h4D);
        put32(TFSIZE); put32(0); put32(1078);
        put32(40); put32(TW); put32(TH);
        put16(1); put16(8); put32(0);
        put32(TSTRIDE * TH); put32(TPPM); put32(TPPM);
        put32(256); put32(0);
        for (int k = 0; k < 256; k++) begin
            push8(8'(k)); push8(8'(k)); push8(8'(k)); push8(8'h00);
        end
    endtask

    task automatic accept_pixel();
        logic last_pix;
        last_pix = (pix_n == NPIX - 1);
        sb.push_back({(TPAD == 0) && last_pix, 8'(8'h10 + pix_n)});
        if ((pix_n % TW) == TW - 1) begin
            for (int p = 0; p < TPAD; p++) sb.push_back({last_pix && (p == TPAD - 1), 8'h00});
        end
        pix_n++;
    endtask

    // One clock: note pixel acceptance before the edge, then drive the next inputs.
    task automatic step();
        @(negedge clk);
        if (ifc.s_valid && ifc.s_ready && !rst) accept_pixel();
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_b = 1'b0;
        ifc.m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pix_n < NPIX) begin
            ifc.s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            ifc.s_pix   = 8'(8'h10 + pix_n);
        end else begin
            ifc.s_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] exp;
        if (mon_en && !rst) begin
            if (prev_stall) begin
                check("hold_valid", 32'(ifc.m_valid), 32'd1);
                check("hold_data", 32'(ifc.m_data), 32'(prev_data));
            end
            if (ifc.m_valid && !ifc.m_ready) check("sready_stall", 32'(ifc.s_ready), 32'd0);
            if (busy && (rx_cnt + int'(ifc.m_valid)) < 1078) check("sready_hdr", 32'(ifc.s_ready), 32'd0);
            if (ifc.m_valid && ifc.m_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL sb_underflow: got byte %0h with none expected", ifc.m_data);
                end else begin
                    exp = sb.pop_front();
                    check("byte_data", 32'(ifc.m_data), 32'(exp[7:0]));
                    check("byte_last", 32'(ifc.m_last), 32'(exp[8]));
                end
                if (rx_cnt < 2048) cap[rx_cnt] = ifc.m_data;
                rx_cnt++;
            end
            if (done) done_cnt++;
        end
        prev_stall = mon_en && !rst && ifc.m_valid && !ifc.m_ready;
        prev_data  = ifc.m_data;
    end

    always @(negedge clk) begin
        if (!rst && ifc_b.m_valid && ifc_b.m_ready && big_cnt < 1078) begin
            big_cap[big_cnt] = ifc_b.m_data;
            big_cnt++;
        end
    end

    task automatic run_file(input string tag, input bit use_bp, input bit use_gaps, input bit second_start);
        int cyc;
        bit sent2;
        bp = use_bp; gaps = use_gaps;
        pix_n = 0; rx_cnt = 0; done_cnt = 0; cyc = 0; sent2 = 0;
        sb.delete();
        push_prefix();
        start = 1'b1;
        ifc.s_valid = 1'b1;
        ifc.s_pix   = 8'h10;
        step();
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        while (done_cnt == 0 && cyc < 20000) begin
            step();
            cyc++;
            if (second_start && !sent2 && pix_n == 2) begin
                start = 1'b1;
                sent2 = 1;
            end
        end
        for (int i = 0; i < 5; i++) step();
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_byte_cnt"}, 32'(rx_cnt), 32'(TFSIZE));
        check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_valid_end"}, 32'(ifc.m_valid), 32'd0);
        check({tag, "_first_byte"}, 32'(cap[0]), 32'h42);
    endtask

    initial begin
        int         idxs[24];
        logic [7:0] vals[24];
        logic [7:0] tail[8];
        int         cyc;

        rst = 1'b1; start = 1'b1; start_b = 1'b1;
        bp = 0; gaps = 0; pix_n = NPIX;
        ifc.s_valid = 1'b0; ifc.s_pix = 8'h00; ifc.m_ready = 1'b1;
        ifc_b.s_valid = 1'b0; ifc_b.s_pix = 8'h00; ifc_b.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; start_b = 1'b0;
        @(negedge clk);
        check("rst_m_valid", 32'(ifc.m_valid), 32'd0);
        check("rst_m_last", 32'(ifc.m_last), 32'd0);
        check("rst_m_data", 32'(ifc.m_data), 32'd0);
        check("rst_s_ready", 32'(ifc.s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        step();
        check("rst_wins_busy", 32'(busy), 32'd0);

        // 400x400 header and palette
        start_b = 1'b1;
        step();
        cyc = 0;
        while (big_cnt < 1078 && cyc < 5000) begin
            step();
            cyc++;
        end
        check("big_prefix_cnt", 32'(big_cnt), 32'd1078);
        idxs = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 13, 18, 19, 34, 35, 36, 37,
                 54, 55, 56, 57, 1074, 1075, 1076, 1077};
        vals = '{8'h42, 8'h4D, 8'h36, 8'h75, 8'h02, 8'h00, 8'h36, 8'h04, 8'h00, 8'h00,
                 8'h90, 8'h01, 8'h00, 8'h71, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'hFF, 8'hFF, 8'hFF, 8'h00};
        for (int i = 0; i < 24; i++) begin
            check($sformatf("big_byte_%0d", idxs[i]), 32'(big_cap[idxs[i]]), 32'(vals[i]));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("big_abort_valid", 32'(ifc_b.m_valid), 32'd0);
        check("big_abort_busy", 32'(busy_b), 32'd0);
        check("big_abort_done", 32'(done_b), 32'd0);

        mon_en = 1'b1;
        run_file("plain", 0, 0, 1);
        tail = '{8'h10, 8'h11, 8'h12, 8'h00, 8'h13, 8'h14, 8'h15, 8'h00};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pad_byte_%0d", 1078 + i), 32'(cap[1078 + i]), 32'(tail[i]));
        end

        run_file("bp", 1, 1, 0);

        // Abort in the middle of the palette, then a fresh file
        bp = 0; gaps = 0; pix_n = 0; rx_cnt = 0; done_cnt = 0;
        sb.delete();
        push_prefix();
        start = 1'b1;
        ifc.s_valid = 1'b1;
        cyc = 0;
        while (rx_cnt < 600 && cyc < 5000) begin
            step();
            cyc++;
        end
        check("abort_reached_600", 32'(rx_cnt >= 600), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_m_valid", 32'(ifc.m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_s_ready", 32'(ifc.s_ready), 32'd0);
        pix_n = NPIX;
        repeat (3) step();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_file("restart", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
